clkdiv_gen: RTL and testbench
=============================

Name: clkdiv_gen

Overview:
- Parametrised, multi-channel, all-digital clock generator that runs from `refclk`.
- Produces NUM_CLK registered divided clocks, each with a programmable divide ratio, high time and phase offset.
- Also produces a one-cycle enable pulse per channel at each rising edge of that channel's clock.
- Has a `locked` indicator, and channels can be reconfigured at runtime through a valid/ready config port.
- Sits next to the PLL and serves low-rate logic and slow peripheral timing.

Parameters:
- NUM_CLK, 4, number of output channels (1..16).
- DIV_W, 8, width of the divide, high-time and phase fields.
- LOCK_CYCLES, 16, number of refclk cycles of stable running before `locked` asserts (≥1).
- DEF_DIV, 2, reset divide ratio for every channel (≥2). Reset high time is DEF_DIV/2 and reset phase is 0.

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer happens when cfg_valid & cfg_ready.
- cfg_chan  in  8  target channel index.
- cfg_div  in  DIV_W  divide ratio N.
- cfg_high  in  DIV_W  high time H, in refclk cycles.
- cfg_phase  in  DIV_W  delay P, in refclk cycles, relative to the common epoch.
- outclk  out  NUM_CLK  divided clocks (registered).
- clk_en  out  NUM_CLK  one-refclk pulse per channel period.
- locked  out  1  all channels aligned and running stable.

Behaviour:
- Reset (async, rst_n=0):
  - outclk, clk_en, locked and cfg_ready are all 0 immediately.
  - Every channel reverts to div=DEF_DIV, high=DEF_DIV/2, phase=0.
  - The FSM goes to RESET.
  - An assertion mid-operation aborts everything; no pending config survives.
- FSM states: RESET → ALIGN → SETTLE → LOCKED.
  - RESET lasts exactly 1 cycle after deassertion, then goes to ALIGN.
  - ALIGN lasts 1 cycle.
    - Every channel's counter is loaded with (P==0 ? 0 : N−P).
    - outclk and clk_en are forced to 0.
    - The lock counter is cleared.
    - It then goes to SETTLE.
  - SETTLE counts LOCK_CYCLES cycles, then goes to LOCKED.
  - LOCKED holds until a valid reconfig is accepted, then goes to ALIGN.
- locked = 1 only in the LOCKED state, as a registered output. After reset release, locked rises on the (2+LOCK_CYCLES)-th rising edge, i.e. the 18th with the defaults.
- cfg_ready:
  - Is 1 in SETTLE and LOCKED, and 0 in RESET and ALIGN.
  - Is independent of cfg_valid in the same cycle.
- Config acceptance (cfg_valid & cfg_ready):
  - If cfg_chan < NUM_CLK:
    - Store the clamped N/H/P for that channel.
    - The next state is ALIGN; all channels realign, not just the target.
    - locked drops on that same edge.
  - If cfg_chan ≥ NUM_CLK:
    - The transfer completes; no state, timing or locked change occurs.
- Clamping, applied at store time:
  - N<2 → 2.
  - H==0 → 1.
  - H≥N → N−1.
  - P≥N → N−1. The P clamp uses the already-clamped N.
- Per-channel counter:
  - Counts cnt = 0..N−1 and wraps N−1 → 0.
  - It runs in SETTLE and LOCKED.
- Output timing:
  - outclk[i] is registered: outclk[i](t+1) = (cnt[i](t) < H).
  - clk_en[i](t+1) = (cnt[i](t) == 0), so clk_en is high in the same cycle that outclk rises.
  - Period is N cycles, with H high and N−H low.
  - A channel with phase P rises exactly P cycles after a channel of equal N with phase 0.
  - The first rising edge after ALIGN, for P=0, appears 2 edges after the ALIGN edge, i.e. 1 cycle of output latency.
- Back-to-back configs: a second request waits out ALIGN with cfg_ready=0, then is accepted in SETTLE. The lock count restarts on each realign.
- Counters and fields are DIV_W bits wide. Arithmetic is unsigned, and no overflow is possible after clamping.

Test Plan:
- Reset release with defaults, N=2, H=1, P=0 → all outclk toggle at refclk/2 in phase; clk_en pulses every 2nd cycle; locked rises on edge 18 and stays high; cfg_ready rises on edge 2.
- Config chan1 N=5, H=2, P=0 → locked drops on the accept edge. outclk[1] is 2 high, 3 low. clk_en[1] pulses every 5 cycles, aligned with the outclk[1] rise. locked returns 1+16 cycles later. Other channels are realigned but keep their ratios.
- Config chan0 N=4, H=2, P=0, then chan2 N=4, H=2, P=1 → the outclk[2] rise lags outclk[0] by exactly 1 refclk cycle, every period.
- Clamping:
  - N=0 → period 2.
  - N=4, H=7 → 3 high, 1 low.
  - N=4, P=9 → lags a P=0 channel by 3 cycles.
- cfg_chan=7 with NUM_CLK=4, while LOCKED → the transfer completes (valid & ready); locked stays 1; no outclk phase or period change.
- Assert rst_n mid-period, between edges → all outputs are 0 before the next edge. On release, defaults are restored and the full lock sequence repeats, with locked back on edge 18.

Source files
------------

// File: rtl/clkdiv_gen.sv
// rtl/clkdiv_gen.sv - multi-channel programmable clock divider with phase alignment and lock
// Channels realign to a common epoch after reset and after every accepted reconfig.
module clkdiv_gen #(
  parameter int NUM_CLK     = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_chan,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_high,
  input  logic [DIV_W-1:0]   cfg_phase,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] clk_en,
  output logic               locked
);

  localparam int LCW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t             r_state;
  logic [LCW-1:0]     r_lock_cnt;
  logic               r_locked;
  logic [DIV_W-1:0]   r_div   [NUM_CLK];
  logic [DIV_W-1:0]   r_high  [NUM_CLK];
  logic [DIV_W-1:0]   r_phase [NUM_CLK];
  logic [DIV_W-1:0]   r_cnt   [NUM_CLK];
  logic [NUM_CLK-1:0] r_outclk;
  logic [NUM_CLK-1:0] r_clk_en;

  logic [DIV_W-1:0]   w_n;
  logic [DIV_W-1:0]   w_h;
  logic [DIV_W-1:0]   w_p;
  logic               w_accept;
  logic               w_hit;

  // Phase clamp depends on the already-clamped divide ratio.
  always_comb begin
    w_n = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    if (cfg_high == '0) begin
      w_h = DIV_W'(1);
    end else if (cfg_high >= w_n) begin
      w_h = w_n - DIV_W'(1);
    end else begin
      w_h = cfg_high;
    end
    w_p = (cfg_phase >= w_n) ? (w_n - DIV_W'(1)) : cfg_phase;
  end

  assign cfg_ready = (r_state == ST_SETTLE) || (r_state == ST_LOCKED);
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_hit     = w_accept & (cfg_chan < 8'(NUM_CLK));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      for (int i = 0; i < NUM_CLK; i++) begin
        r_div[i]   <= DIV_W'(DEF_DIV);
        r_high[i]  <= DIV_W'(DEF_DIV / 2);
        r_phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLK; i++) begin
        if (w_hit && (cfg_chan == 8'(i))) begin
          r_div[i]   <= w_n;
          r_high[i]  <= w_h;
          r_phase[i] <= w_p;
        end
      end
      case (r_state)
        ST_RESET: begin
          r_state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          r_lock_cnt <= '0;
          r_state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_hit) begin
            r_state <= ST_ALIGN;
          end else if (r_lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + LCW'(1);
          end
        end
        ST_LOCKED: begin
          if (w_hit) begin
            r_state  <= ST_ALIGN;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RESET;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Preloading N-P makes a phased channel reach zero P cycles after the epoch.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_outclk <= '0;
      r_clk_en <= '0;
      for (int i = 0; i < NUM_CLK; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_ALIGN: begin
          r_outclk <= '0;
          r_clk_en <= '0;
          for (int i = 0; i < NUM_CLK; i++) begin
            r_cnt[i] <= (r_phase[i] == '0) ? '0 : (r_div[i] - r_phase[i]);
          end
        end
        ST_SETTLE, ST_LOCKED: begin
          for (int i = 0; i < NUM_CLK; i++) begin
            r_outclk[i] <= (r_cnt[i] < r_high[i]);
            r_clk_en[i] <= (r_cnt[i] == '0);
            r_cnt[i]    <= (r_cnt[i] == (r_div[i] - DIV_W'(1))) ? '0 : (r_cnt[i] + DIV_W'(1));
          end
        end
        default: begin
          r_outclk <= '0;
          r_clk_en <= '0;
        end
      endcase
    end
  end

  assign outclk = r_outclk;
  assign clk_en = r_clk_en;
  assign locked = r_locked;

endmodule

// File: tb/tb_clkdiv_gen.sv
// tb/tb_clkdiv_gen.sv - directed table-driven bench for clkdiv_gen
module tb_clkdiv_gen;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int WIN = 40;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_high = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic [NC-1:0] outclk;
  logic [NC-1:0] clk_en;
  logic          locked;

  int errors = 0;
  int checks = 0;

  logic [NC-1:0] sc [WIN];
  logic [NC-1:0] se [WIN];

  typedef struct {
    logic [7:0] chan;
    logic [7:0] div;
    logic [7:0] high;
    logic [7:0] phase;
    int         refc;
    int         exp_n;
    int         exp_h;
    int         exp_lag;
  } vec_t;

  vec_t vt [7];

  clkdiv_gen #(.NUM_CLK(NC), .DIV_W(DW), .LOCK_CYCLES(16), .DEF_DIV(2)) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .clk_en    (clk_en),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic int find_rise(input int c, input int from);
    for (int k = from; k < WIN; k++) begin
      if (k >= 1 && sc[k][c] && !sc[k-1][c]) return k;
    end
    return -1;
  endfunction

  task automatic reset_seq();
    int first_lock;
    first_lock = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) chk("ready_e1", 32'(cfg_ready), 0);
      if (e == 2) chk("ready_e2", 32'(cfg_ready), 1);
      if (e == 3 || e == 5) begin
        chk("def_clk_hi", 32'(outclk), 32'hF);
        chk("def_en_hi", 32'(clk_en), 32'hF);
      end
      if (e == 4 || e == 6) begin
        chk("def_clk_lo", 32'(outclk), 0);
        chk("def_en_lo", 32'(clk_en), 0);
      end
      if (locked && first_lock == 0) first_lock = e;
    end
    chk("lock_edge", 32'(first_lock), 18);
    chk("locked_hold", 32'(locked), 1);
  endtask

  task automatic do_cfg(input logic [7:0] ch, input logic [7:0] d, input logic [7:0] h,
                        input logic [7:0] p);
    int waited;
    waited = 0;
    cfg_chan  = ch;
    cfg_div   = d;
    cfg_high  = h;
    cfg_phase = p;
    cfg_valid = 1'b1;
    while (!cfg_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, kr, k2, hi, en, kref, kc, c, mism, lk_bad, tr_ok;
    logic [NC-1:0] hist [24];

    vt[0] = '{8'd1, 8'd5, 8'd2, 8'd0, -1, 5, 2, 0};
    vt[1] = '{8'd0, 8'd4, 8'd2, 8'd0, -1, 4, 2, 0};
    vt[2] = '{8'd2, 8'd4, 8'd2, 8'd1,  0, 4, 2, 1};
    vt[3] = '{8'd3, 8'd0, 8'd1, 8'd0, -1, 2, 1, 0};
    vt[4] = '{8'd2, 8'd4, 8'd7, 8'd0,  0, 4, 3, 0};
    vt[5] = '{8'd2, 8'd4, 8'd2, 8'd9,  0, 4, 2, 3};
    vt[6] = '{8'd1, 8'd1, 8'd0, 8'd0, -1, 2, 1, 0};

    #2;
    chk("rst_outclk", 32'(outclk), 0);
    chk("rst_clk_en", 32'(clk_en), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    #10;
    rst_n = 1'b1;
    reset_seq();

    for (int v = 0; v < 7; v++) begin
      c = int'(vt[v].chan);
      do_cfg(vt[v].chan, vt[v].div, vt[v].high, vt[v].phase);
      chk("accept_drop", 32'(locked), 0);
      tick();
      chk("align_zero", 32'(outclk), 0);
      tick();
      chk("p0_rise", 32'(outclk[0]), 1);
      n = 2;
      while (!locked && n < 60) begin
        tick();
        n++;
      end
      chk("relock_cycles", 32'(n), 17);
      for (int k = 0; k < WIN; k++) begin
        sc[k] = outclk;
        se[k] = clk_en;
        tick();
      end
      kr = find_rise(c, 1);
      k2 = find_rise(c, kr + 1);
      chk("period", 32'(k2 - kr), 32'(vt[v].exp_n));
      if (kr < 1) kr = 1;
      if (k2 <= kr) k2 = kr + 1;
      hi = 0;
      en = 0;
      for (int k = kr; k < k2; k++) begin
        if (sc[k][c]) hi++;
        if (se[k][c]) en++;
      end
      chk("high_time", 32'(hi), 32'(vt[v].exp_h));
      chk("en_count", 32'(en), 1);
      chk("en_at_rise", 32'(se[kr][c]), 1);
      if (vt[v].refc >= 0) begin
        kref = find_rise(vt[v].refc, 1);
        kc = find_rise(c, (kref < 1) ? 1 : kref);
        chk("phase_lag", 32'(kc - kref), 32'(vt[v].exp_lag));
      end
    end

    lk_bad = 0;
    tr_ok = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 8) begin
        cfg_chan  = 8'd7;
        cfg_div   = 8'd3;
        cfg_high  = 8'd1;
        cfg_phase = 8'd1;
        cfg_valid = 1'b1;
        tr_ok = int'(cfg_ready);
      end
      tick();
      if (k == 8) cfg_valid = 1'b0;
      hist[k] = outclk;
      if (!locked) lk_bad++;
    end
    mism = 0;
    for (int k = 4; k < 24; k++) begin
      if (hist[k] != hist[k-4]) mism++;
    end
    chk("inv_handshake", 32'(tr_ok), 1);
    chk("inv_locked", 32'(lk_bad), 0);
    chk("inv_periodic", 32'(mism), 0);
    chk("inv_toggle", 32'(hist[10][1] ^ hist[11][1]), 1);

    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outclk", 32'(outclk), 0);
    chk("mid_rst_clk_en", 32'(clk_en), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 0);
    #2;
    rst_n = 1'b1;
    reset_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
